uart_rx: RTL

//  Serial receive end of the UART. Samples the asynchronous rx line in the clk_in domain,

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t        : receiver FSM state encoding
//   DIV_DEFAULT       : clk_in cycles per bit (100 MHz / 115200)
//   DATA_BITS_DEFAULT : data bits per frame
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int DIV_DEFAULT       = 868;
  localparam int DATA_BITS_DEFAULT = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line.
// Resets to 1 so the idle line never looks like a start bit.
//   clk_in : system clock
//   rst    : asynchronous, active-high reset
//   d      : asynchronous input
//   q      : synchronized output (2-cycle delay)
module uart_rx_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit detect, mid-bit sampling, LSB-first data recovery.
// Optional even-parity bit when UART_RX_PARITY_EN is defined (default: 8N1).
//   clk_in      : system clock
//   rst         : asynchronous, active-high reset
//   rx          : serial line, idle high, asynchronous
//   data_out    : last good byte, held until the next good frame
//   data_valid  : one-cycle pulse, data_out updated
//   framing_err : one-cycle pulse, stop bit sampled low
//   parity_err  : one-cycle pulse, parity mismatch (0 without UART_RX_PARITY_EN)
//   busy        : high from start detect until back in IDLE
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a falling edge on rx_s (line must be seen high)
// ST_START  | half-bit wait, then confirm start bit is still low
// ST_DATA   | sample one data bit per bit period, LSB first
// ST_PARITY | sample the parity bit (parity builds only)
// ST_STOP   | sample the stop bit, issue strobe, return to IDLE mid-stop
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIV       = DIV_DEFAULT,
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(DATA_BITS);

  logic rx_s;

  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt, ferr_nxt;
  logic                 seen_high, seen_nxt;
  logic                 cnt_last;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_nxt;
  logic                 perr_nxt;
`endif

  uart_rx_sync u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (rx),
    .q      (rx_s)
  );

  assign busy     = (state != ST_IDLE);
  assign cnt_last = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      seen_high   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      shift       <= shift_nxt;
      data_out    <= data_nxt;
      data_valid  <= valid_nxt;
      framing_err <= ferr_nxt;
      seen_high   <= seen_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bit    <= par_nxt;
      parity_err <= perr_nxt;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    // Only a high level seen while idle arms start detection, so a line held
    // low after a broken frame is not mistaken for a new start bit.
    seen_nxt  = (state == ST_IDLE) && rx_s;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_bit;
    perr_nxt  = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        if (!rx_s && seen_high) begin
          state_nxt = ST_START;
          cnt_nxt   = '0;
        end
      end

      ST_START: begin
        if (cnt == CNT_W'(DIV / 2 - 1)) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DATA;
            idx_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_last) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_s;
          if (idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_last) begin
          cnt_nxt   = '0;
          par_nxt   = rx_s;
          state_nxt = ST_STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif

      ST_STOP: begin
        if (cnt_last) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
          if (!rx_s) begin
            ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{shift, par_bit}) begin
            perr_nxt = 1'b1;
`endif
          end else begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
